// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants and state encoding for the memory access controller.
package mem_access_ctrl_pkg;

    // Default geometry of the small memory block; the memory model uses these too.
    localparam int              DEF_ADDR_W  = 3;
    localparam int              DEF_DATA_W  = 3;
    localparam logic [2:0]      DEF_PATTERN = 3'b101;

    // Read-latency counter width; RD_LAT is limited to 1..4, so RD_LAT-1 fits in 2 bits.
    localparam int              CNT_W       = 2;

    typedef enum logic [2:0] {
        IDLE,
        H_WR,
        H_RD,
        H_WAIT,
        S_WR,
        S_RD,
        S_WAIT,
        S_END
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_lat.sv
// Read-latency down-counter shared by the host-read and sweep-read paths.
module mem_rd_latency_ctr
    import mem_access_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    // Load on the read-enable cycle, then count down to zero while waiting.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= CNT_W'(RD_LAT - 1);
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Host read/write front-end plus built-in write/readback sweep test for the small memory.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                RD_LAT  = 1,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEF_PATTERN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              sweep_start,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic              sweep_pass,
    output logic [ADDR_W-1:0] sweep_fail_addr,
    output logic              mem_read_ctrl,
    output logic              mem_write_ctrl,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    input  logic [DATA_W-1:0] mem_data_read
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] exp_data;
    logic              cnt_load, cnt_dec, cnt_expire;
    logic              last_addr;

    assign exp_data  = DATA_W'(addr_q) ^ PATTERN;
    assign last_addr = (addr_q == '1);

    mem_rd_latency_ctr #(.RD_LAT(RD_LAT)) u_lat (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load),
        .dec    (cnt_dec),
        .expire (cnt_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and memory/handshake strobes, all decoded from the current state.
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        mem_read_ctrl  = 1'b0;
        mem_write_ctrl = 1'b0;
        mem_data_write = '0;
        rsp_valid      = 1'b0;
        sweep_done     = 1'b0;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)        state_d = req_write ? H_WR : H_RD;
                else if (sweep_start) state_d = S_WR;
            end
            H_WR: begin
                mem_write_ctrl = 1'b1;
                mem_data_write = wdata_q;
                state_d        = IDLE;
            end
            H_RD: begin
                mem_read_ctrl = 1'b1;
                cnt_load      = 1'b1;
                state_d       = H_WAIT;
            end
            H_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_expire) begin
                    rsp_valid = 1'b1;
                    state_d   = IDLE;
                end
            end
            S_WR: begin
                mem_write_ctrl = 1'b1;
                mem_data_write = exp_data;
                if (last_addr) state_d = S_RD;
            end
            S_RD: begin
                mem_read_ctrl = 1'b1;
                cnt_load      = 1'b1;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_expire) state_d = last_addr ? S_END : S_RD;
            end
            S_END: begin
                sweep_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address/data capture, read-data capture and sweep result tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q          <= '0;
            wdata_q         <= '0;
            rdata_q         <= '0;
            sweep_pass      <= 1'b0;
            sweep_fail_addr <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                    end else if (sweep_start) begin
                        addr_q          <= '0;
                        sweep_pass      <= 1'b1;
                        sweep_fail_addr <= '0;
                    end
                end
                H_WAIT: if (cnt_expire) rdata_q <= mem_data_read;
                // Increment wraps to 0 after the last write, ready for the readback pass.
                S_WR:   addr_q <= addr_q + 1'b1;
                S_WAIT: begin
                    if (cnt_expire) begin
                        // sweep_pass doubles as "no mismatch yet", so only the first one is recorded.
                        if (mem_data_read != exp_data && sweep_pass) begin
                            sweep_pass      <= 1'b0;
                            sweep_fail_addr <= addr_q;
                        end
                        if (!last_addr) addr_q <= addr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data is presented in the strobe cycle itself and held afterwards.
    assign rsp_rdata   = rsp_valid ? mem_data_read : rdata_q;
    assign mem_address = addr_q;
    assign sweep_busy  = (state_q == S_WR) || (state_q == S_RD) ||
                         (state_q == S_WAIT) || (state_q == S_END);

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator-side controller for the small synchronous memory block (`mem_read_ctrl` / `mem_write_ctrl` / `mem_address` / `mem_data_write` / `mem_data_read` interface). It accepts single read or write requests from a host over a valid/ready handshake and converts them into correctly timed memory control pulses. It returns read data with a response strobe. It also runs a built-in sweep test: write a pattern to every address, read everything back, and report pass/fail.

## Interface
- `ADDR_W`, default 3: memory address width; depth = 2^ADDR_W.
- `DATA_W`, default 3: memory data width.
- `RD_LAT`, default 1: cycles from the edge that samples `mem_read_ctrl`=1 until `mem_data_read` is valid; legal range 1..4.
- `PATTERN`, default 3'b101: sweep write data is `addr[DATA_W-1:0] ^ PATTERN`.

Ports:
- `clk` in 1: single clock; all logic uses the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: host request present.
- `req_ready` out 1: controller can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: request address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: one-cycle strobe; `rsp_rdata` holds valid read data.
- `rsp_rdata` out DATA_W: captured read data; held until the next read response.
- `sweep_start` in 1: start the sweep test; sampled only in IDLE.
- `sweep_busy` out 1: sweep in progress.
- `sweep_done` out 1: one-cycle strobe at the end of a sweep.
- `sweep_pass` out 1: result of the last sweep; held until the next sweep starts.
- `sweep_fail_addr` out ADDR_W: first mismatching address; 0 if the sweep passed.
- `mem_read_ctrl` out 1: memory read enable.
- `mem_write_ctrl` out 1: memory write enable.
- `mem_address` out ADDR_W: memory address.
- `mem_data_write` out DATA_W: memory write data.
- `mem_data_read` in DATA_W: memory read data.

## Operation
- **States:** IDLE, H_WR, H_RD, H_WAIT, S_WR, S_RD, S_WAIT, S_END.
- **IDLE:** `req_ready`=1.
  - If `req_valid`=1, the request is accepted: address and data are registered. Next state is H_WR if `req_write`=1, otherwise H_RD.
  - Else if `sweep_start`=1, next state is S_WR with address 0, `sweep_pass` set to 1, `sweep_fail_addr` set to 0.
  - A host request takes priority over `sweep_start` when both arrive in the same cycle; the sweep is not latched.
- **H_WR:** `mem_write_ctrl`=1 with the registered address and data for exactly one cycle, then IDLE.
- **H_RD:** `mem_read_ctrl`=1 for one cycle, then H_WAIT. The wait counter is loaded with RD_LAT-1.
- **H_WAIT:** the counter decrements each cycle. At 0, `mem_data_read` is captured into `rsp_rdata`, `rsp_valid`=1 for that cycle, and the next state is IDLE.
- **S_WR:** one write per cycle, data = `addr ^ PATTERN`. After the write to the last address, the address wraps to 0 and the next state is S_RD.
- **S_RD / S_WAIT:** same timing as H_RD / H_WAIT. On capture, the read data is compared with `addr ^ PATTERN`.
  - On the first mismatch, `sweep_pass` is cleared and `sweep_fail_addr` is set to that address. Later mismatches do not change either output.
  - After the last address the next state is S_END; otherwise the address increments and the next state is S_RD.
- **S_END:** `sweep_done`=1 for one cycle, then IDLE.
- The sweep does not drive `rsp_valid`. `req_ready`=0 in every state except IDLE.
- `mem_read_ctrl` and `mem_write_ctrl` are never both 1 in the same cycle.
- `mem_data_write` is driven only during writes and is 0 otherwise. `mem_address` holds its last value between accesses.

## Timing
- **Reset values:** state IDLE, `req_ready`=1 after reset; all other outputs 0, including `sweep_pass` and `rsp_rdata`.
- **Reset mid-operation:** returns to IDLE on the next edge. Memory enables drop in that same edge. No `rsp_valid` or `sweep_done` is issued for the aborted operation.
- **Write latency:** accept edge → `mem_write_ctrl` high for the following cycle. Throughput is one write per 2 cycles.
- **Read latency:** accept edge → `mem_read_ctrl` high 1 cycle later → `rsp_valid` RD_LAT cycles after that. Total from accept to `rsp_valid` is 1+RD_LAT cycles.
- **Sweep duration:** from `sweep_start` sampled to the `sweep_done` cycle is DEPTH + DEPTH·(1+RD_LAT) + 1 cycles. With the defaults that is 8+16+1 = 25.
- **Handshake:** a transfer occurs only on an edge where `req_valid` and `req_ready` are both 1. `req_*` fields need not be held after acceptance.

## Structure
- A shared package holds:
  - the state enum;
  - the default `ADDR_W` / `DATA_W` / `PATTERN` constants, which the memory block also uses.
- Natural sub-module: `mem_rd_latency_ctr`, a down-counter loaded with RD_LAT-1 that raises `expire` at 0. It is shared by the host-read and sweep-read paths.
- The memory model is instantiated only in the bench, not inside this block.

## Test plan
1. **Reset then host write:** write addr 3'b000 data 3'b010, then addr 3'b001 data 3'b101 → `mem_write_ctrl` pulses 1 cycle each with matching address and data; `req_ready` is low during each write cycle.
2. **Host read after (1):** reads of addr 0 and addr 1 → `rsp_valid` 1+RD_LAT cycles after each accept, with `rsp_rdata` 3'b010 then 3'b101.
3. **Sweep on a good memory:** pulse `sweep_start` → exactly 8 writes of `addr ^ 3'b101`, 8 reads, `sweep_done` at cycle 25, `sweep_pass`=1, `sweep_fail_addr`=0.
4. **Sweep with the bench corrupting the readback of addr 5 and addr 6** → `sweep_pass`=0 and `sweep_fail_addr`=5.
5. **`req_valid` and `sweep_start` both high in IDLE** → the host request is served and no sweep starts. **`req_valid` during a sweep** → `req_ready` stays 0 until `sweep_done`, then the request is accepted.
6. **`rst` pulsed in S_RD and in H_WAIT** → IDLE next cycle, no `rsp_valid` or `sweep_done`, enables 0. Rerun with RD_LAT=3 and check the scenario (2) latency is 4 cycles.
